// File: rtl/icache_axi_refill.sv
// icache_axi_refill: refills one 32-byte ICache line with a single 8-beat AXI4 INCR read burst
// Ports:
//   clk, rst (async, active-low)
//   mem_inst_ren_i/mem_inst_araddr_i   : level-held miss request from the cache
//   mem_inst_rvalid_o/rdata_o/rerr_o   : one-cycle line-return pulse, 256-bit line, error flag
//   arid/araddr/arlen/arsize/arburst/arvalid/arready : AXI read-address channel
//   rid/rdata/rresp/rlast/rvalid/rready              : AXI read-data channel (rid ignored)
module icache_axi_refill #(
  parameter logic [3:0] AXI_ID = 4'b0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_inst_ren_i,
  input  logic [31:0]  mem_inst_araddr_i,
  output logic         mem_inst_rvalid_o,
  output logic [255:0] mem_inst_rdata_o,
  output logic         mem_inst_rerr_o,
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arvalid,
  input  logic         arready,
  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready
);
  typedef enum logic [1:0] {IDLE, AR, R, DONE} state_t;
  state_t state, state_nx;
  logic [255:0] line;
  logic [2:0] cnt;
  logic err, abort;
  logic unused_bits;
  assign unused_bits = ^{rid, mem_inst_araddr_i[4:0]};
  assign arid = AXI_ID;
  assign arlen = 8'd7;
  assign arsize = 3'b010;
  assign arburst = 2'b01;
  assign mem_inst_rdata_o = line;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    arvalid = 1'b0;
    rready = 1'b0;
    mem_inst_rvalid_o = 1'b0;
    mem_inst_rerr_o = 1'b0;
    case (state)
      IDLE: state_nx = mem_inst_ren_i ? AR : IDLE;
      AR: begin
        arvalid = 1'b1;
        state_nx = arready ? R : AR;
      end
      R: begin
        rready = 1'b1;
        state_nx = (rvalid && (rlast || cnt == 3'd7)) ? DONE : R;
      end
      default: begin
        mem_inst_rvalid_o = !abort;
        mem_inst_rerr_o = !abort && err;
        state_nx = IDLE;
      end
    endcase
  end
  // A beat is a length error whenever rlast disagrees with this being the 8th beat.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      araddr <= '0;
      line <= '0;
      cnt <= '0;
      err <= 1'b0;
      abort <= 1'b0;
    end else begin
      case (state)
        IDLE: if (mem_inst_ren_i) begin
          araddr <= {mem_inst_araddr_i[31:5], 5'b0};
          line <= '0;
          cnt <= '0;
          err <= 1'b0;
          abort <= 1'b0;
        end
        AR: if (!mem_inst_ren_i) abort <= 1'b1;
        R: begin
          if (!mem_inst_ren_i) abort <= 1'b1;
          if (rvalid) begin
            line[{cnt, 5'b0} +: 32] <= rdata;
            cnt <= cnt + 3'd1;
            err <= err | (rresp != 2'b00) | (rlast != (cnt == 3'd7));
          end
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_icache_axi_refill.sv
// tb_icache_axi_refill: randomized AXI-slave driver with a per-burst transaction-level reference model
module tb_icache_axi_refill;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic mem_inst_ren_i = 1'b0;
  logic [31:0] mem_inst_araddr_i = '0;
  logic mem_inst_rvalid_o;
  logic [255:0] mem_inst_rdata_o;
  logic mem_inst_rerr_o;
  logic [3:0] arid;
  logic [31:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic arvalid;
  logic arready = 1'b0;
  logic [3:0] rid = '0;
  logic [31:0] rdata = '0;
  logic [1:0] rresp = '0;
  logic rlast = 1'b0;
  logic rvalid = 1'b0;
  logic rready;
  int tests = 0;
  int fails = 0;
  logic [31:0] dat [8];

  icache_axi_refill #(.AXI_ID(4'b0000)) dut (
    .clk(clk), .rst(rst),
    .mem_inst_ren_i(mem_inst_ren_i), .mem_inst_araddr_i(mem_inst_araddr_i),
    .mem_inst_rvalid_o(mem_inst_rvalid_o), .mem_inst_rdata_o(mem_inst_rdata_o),
    .mem_inst_rerr_o(mem_inst_rerr_o),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // d: arready wait cycles; bub[j]: one rvalid bubble before beat j; rl: index of rlast beat
  // (8 = slave never asserts rlast); errm[j]: beat j answers SLVERR; drop_at: cycle ren goes low
  // (0 none, -1 random); rst_at: cycle reset is asserted (0 none). Cycle 1 follows the request edge.
  task automatic run_txn(input logic [31:0] addr, input int d, input logic [7:0] bub, input int rl,
                         input logic [7:0] errm, input int drop_at_in, input int rst_at);
    int n, b, done, cyc, beat, arcnt, pulses, pcyc, drop_at;
    logic experr, abort, bubbled, bad_addr, hs, goterr, rdy_at_pulse;
    logic [255:0] expl, gotl;
    n = (rl < 8) ? rl + 1 : 8;
    b = 0;
    experr = (rl != 7);
    expl = '0;
    for (int k = 0; k < n; k++) begin
      b += int'(bub[k]);
      experr |= errm[k];
      expl[k*32 +: 32] = dat[k];
    end
    done = 2 + d + n + b;
    drop_at = (drop_at_in < 0) ? $urandom_range(1, done - 1) : drop_at_in;
    abort = (drop_at > 0) && (drop_at < done);
    beat = 0; arcnt = 0; pulses = 0; pcyc = 0; bubbled = 1'b0; bad_addr = 1'b0;
    goterr = 1'b0; gotl = '0; rdy_at_pulse = 1'b0;
    @(negedge clk);
    mem_inst_ren_i = 1'b1;
    mem_inst_araddr_i = addr;
    @(posedge clk);
    cyc = 1;
    while (cyc <= done) begin
      @(negedge clk);
      if (cyc == rst_at) begin
        rst = 1'b0;
        #1;
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_rvalid_o", mem_inst_rvalid_o, 0);
        chk("rst_rerr_o", mem_inst_rerr_o, 0);
        chk("rst_rdata_o", mem_inst_rdata_o, 0);
        chk("rst_araddr", araddr, 0);
        mem_inst_ren_i = 1'b0; rvalid = 1'b0; arready = 1'b0; rlast = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        return;
      end
      if (cyc == drop_at) mem_inst_ren_i = 1'b0;
      if (arvalid) begin
        arcnt++;
        bad_addr |= (araddr != {addr[31:5], 5'b0});
      end
      if (mem_inst_rvalid_o) begin
        pulses++;
        pcyc = cyc;
        gotl = mem_inst_rdata_o;
        goterr = mem_inst_rerr_o;
        rdy_at_pulse = rready;
        mem_inst_ren_i = 1'b0;
      end
      arready = arvalid && (arcnt == d + 1);
      hs = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
      if (rready && beat < 8) begin
        if (bub[beat] && !bubbled) bubbled = 1'b1;
        else begin
          rvalid = 1'b1;
          rdata = dat[beat];
          rresp = errm[beat] ? 2'b10 : 2'b00;
          rlast = (beat == rl);
          hs = 1'b1;
        end
      end
      @(posedge clk);
      if (hs) begin
        beat++;
        bubbled = 1'b0;
      end
      cyc++;
    end
    rvalid = 1'b0; arready = 1'b0; rlast = 1'b0;
    chk("beats", beat, n);
    chk("ar_cycles", arcnt, d + 1);
    chk("ar_addr_stable", bad_addr, 0);
    if (abort) chk("abort_pulses", pulses, 0);
    else begin
      chk("pulses", pulses, 1);
      chk("pulse_cycle", pcyc, done);
      chk("line", gotl, expl);
      chk("rerr", goterr, experr);
      chk("rready_at_pulse", rdy_at_pulse, 0);
    end
  endtask

  task automatic seq_data();
    for (int k = 0; k < 8; k++) dat[k] = 32'h1000_0000 + k;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_arvalid", arvalid, 0);
    chk("reset_rready", rready, 0);
    chk("reset_rvalid_o", mem_inst_rvalid_o, 0);
    chk("reset_rdata_o", mem_inst_rdata_o, 0);
    chk("reset_araddr", araddr, 0);
    chk("ar_const", {arid, arlen, arsize, arburst}, {4'b0000, 8'd7, 3'b010, 2'b01});
    rst = 1'b1;
    seq_data();
    run_txn(32'h1FC0_0014, 0, 8'h00, 7, 8'h00, 0, 0);
    run_txn(32'h1FC0_0014, 3, 8'h10, 7, 8'h00, 0, 0);
    run_txn(32'h1FC0_0014, 0, 8'h00, 7, 8'h20, 0, 0);
    run_txn(32'h1FC0_0014, 0, 8'h00, 7, 8'h00, 0, 0);
    run_txn(32'h1FC0_0020, 0, 8'h00, 7, 8'h00, 4, 0);
    run_txn(32'h0000_0040, 0, 8'h00, 7, 8'h00, 0, 0);
    run_txn(32'h0000_0100, 0, 8'h00, 4, 8'h00, 0, 0);
    run_txn(32'h0000_0180, 1, 8'h00, 8, 8'h00, 0, 0);
    run_txn(32'h0000_0200, 0, 8'h00, 7, 8'h00, 0, 5);
    run_txn(32'h0000_0300, 0, 8'h00, 7, 8'h00, 0, 0);
    for (int t = 0; t < 30; t++) begin
      int rsel;
      for (int k = 0; k < 8; k++) dat[k] = $urandom;
      rsel = $urandom_range(0, 11);
      run_txn($urandom, $urandom_range(0, 3), 8'($urandom & $urandom), (rsel <= 8) ? rsel : 7,
              ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00,
              ($urandom_range(0, 5) == 0) ? -1 : 0, 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
